// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that turns oversampled sclk/mosi/ss_n frames into single-cycle
// register-file write/read strobes and shifts read data back out on miso.
`timescale 1ns/1ps
module spi_reg_slave #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frame_error
);

  localparam int CMD_BITS   = ADDR_WIDTH + 1;
  localparam int FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
  localparam logic [4:0] DATA_LAST = 5'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    FETCH = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Current FSM state; kept as a named enum so checkers can bind to it.
  state_t state;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic mosi_meta, mosi_sync;
  logic ss_meta, ss_sync;
  logic [1:0] sync_fill;
  logic armed;
  logic sclk_rise, sclk_fall;

  logic [4:0]            bit_cnt;
  logic [CMD_BITS-1:0]   cmd_shift;
  logic [DATA_WIDTH-1:0] data_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  fetch_wait;
  logic                  done_entry;
  logic                  is_read;

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;
  assign is_read   = cmd_shift[CMD_BITS-1];

  // sync_fill marks when ss_sync again reflects the pin after reset, so a
  // frame interrupted by reset is not picked up mid-way; armed needs a real high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
      ss_meta   <= ss_n;
      ss_sync   <= ss_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && ss_sync) begin
        armed <= 1'b1;
      end
    end
  end

  // Strobe contract: wr_en and rd_en are single-cycle pulses with no back-pressure;
  // the register file must accept wr_en unconditionally and return rd_data
  // exactly one cycle after rd_en.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      cmd_shift   <= '0;
      data_shift  <= '0;
      tx_shift    <= '0;
      fetch_wait  <= 1'b0;
      done_entry  <= 1'b0;
      miso        <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      frame_error <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (armed && !ss_sync) begin
            bit_cnt <= '0;
            state   <= CMD;
          end
        end

        CMD: begin
          if (ss_sync) begin
            state       <= IDLE;
            frame_error <= 1'b1;
            miso        <= 1'b0;
          end else if (sclk_rise) begin
            cmd_shift <= {cmd_shift[CMD_BITS-2:0], mosi_sync};
            if (bit_cnt != 5'h1f) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
            if (bit_cnt == CMD_LAST) begin
              // The oldest bit still sits one below the top before this shift.
              if (cmd_shift[CMD_BITS-2]) begin
                state      <= FETCH;
                rd_en      <= 1'b1;
                rd_addr    <= {cmd_shift[ADDR_WIDTH-2:0], mosi_sync};
                fetch_wait <= 1'b0;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        FETCH: begin
          if (ss_sync) begin
            state       <= IDLE;
            frame_error <= 1'b1;
            miso        <= 1'b0;
          end else if (!fetch_wait) begin
            fetch_wait <= 1'b1;
          end else begin
            tx_shift <= rd_data;
            state    <= DATA;
          end
        end

        DATA: begin
          if (ss_sync) begin
            state       <= IDLE;
            frame_error <= 1'b1;
            miso        <= 1'b0;
          end else begin
            if (sclk_rise) begin
              data_shift <= {data_shift[DATA_WIDTH-2:0], mosi_sync};
              if (bit_cnt != 5'h1f) begin
                bit_cnt <= bit_cnt + 5'd1;
              end
              if (bit_cnt == DATA_LAST) begin
                state      <= DONE;
                done_entry <= 1'b1;
              end
            end
            if (sclk_fall && is_read) begin
              miso     <= tx_shift[DATA_WIDTH-1];
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end

        DONE: begin
          miso <= 1'b0;
          if (done_entry) begin
            done_entry <= 1'b0;
            if (!is_read) begin
              wr_en   <= 1'b1;
              wr_addr <= cmd_shift[ADDR_WIDTH-1:0];
              wr_data <= data_shift;
            end
          end else if (ss_sync) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: an SPI master drives frames, a register-file
// model answers reads, and a scoreboard monitor checks every strobe against hand-computed values.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  localparam int AW   = 7;
  localparam int DW   = 16;
  localparam int HALF = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          sclk;
  logic          mosi;
  logic          ss_n;
  logic          miso;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          frame_error;

  always #5 clock = ~clock;

  spi_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .sclk        (sclk),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .miso        (miso),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_error (frame_error)
  );

  // Register-file model: reads return data one cycle after rd_en.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < (1 << AW); i++) begin
        mem[i] <= (i == 'h12) ? 16'hA5C3 : 16'h0000;
      end
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  typedef struct {
    int          id;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic [0:0]       exp_err_q[$];
  chk_t             post_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   miso_bad = 0;
  logic miso_guard = 1'b0;

  function automatic string nm(input int id);
    case (id)
      0:  return "reset_wr_en";
      1:  return "reset_rd_en";
      2:  return "reset_frame_error";
      3:  return "reset_miso";
      4:  return "reset_wr_addr";
      5:  return "reset_wr_data";
      6:  return "reset_rd_addr";
      7:  return "miso_zero_write";
      8:  return "read_miso_word";
      9:  return "wr_q_drained";
      10: return "rd_q_drained";
      11: return "err_q_drained";
      12: return "wr_strobe";
      13: return "rd_strobe";
      default: return "misc";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic post(input int id, input logic [31:0] got, input logic [31:0] exp);
    chk_t c;
    c.id  = id;
    c.got = got;
    c.exp = exp;
    post_q.push_back(c);
  endtask

  // Monitor: all comparisons happen here, on the falling clock edge.
  always @(negedge clock) begin
    chk_t c;
    if (miso_guard && miso !== 1'b0) miso_bad++;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wr_en: got addr 0x%0h data 0x%0h, required no strobe", wr_addr, wr_data);
      end else begin
        check(nm(12), 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
      end
    end
    if (rd_en === 1'b1) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_en: got addr 0x%0h, required no strobe", rd_addr);
      end else begin
        check(nm(13), 32'(rd_addr), 32'(exp_rd_q.pop_front()));
      end
    end
    if (frame_error === 1'b1) begin
      if (exp_err_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_error: got pulse, required none");
      end else begin
        void'(exp_err_q.pop_front());
      end
    end
    while (post_q.size() > 0) begin
      c = post_q.pop_front();
      check(nm(c.id), c.got, c.exp);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    wait_clk(HALF);
    s    = miso;
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [23:0] f, input int npulses, input int gap,
                           output logic [15:0] rx);
    logic s;
    rx   = '0;
    ss_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < npulses; i++) begin
      spi_bit((i < 24) ? f[23-i] : 1'b1, s);
      if (i >= 8 && i < 24) rx = {rx[14:0], s};
    end
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(gap);
  endtask

  task automatic check_outputs_zero();
    post(0, 32'(wr_en), 32'h0);
    post(1, 32'(rd_en), 32'h0);
    post(2, 32'(frame_error), 32'h0);
    post(3, 32'(miso), 32'h0);
    post(4, 32'(wr_addr), 32'h0);
    post(5, 32'(wr_data), 32'h0);
    post(6, 32'(rd_addr), 32'h0);
  endtask

  task automatic check_drained();
    post(9,  32'(exp_q.size()), 32'h0);
    post(10, 32'(exp_rd_q.size()), 32'h0);
    post(11, 32'(exp_err_q.size()), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rx;
    logic        s;
    int          base;
    reset = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss_n  = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    check_outputs_zero();
    wait_clk(6);

    // Write 0x05 = 0xBEEF; miso must stay low.
    base = miso_bad;
    miso_guard = 1'b1;
    exp_q.push_back({7'h05, 16'hBEEF});
    spi_frame(24'h05BEEF, 24, 8, rx);
    miso_guard = 1'b0;
    post(7, 32'(miso_bad - base), 32'h0);
    check_drained();

    // Read 0x12; model holds 0xA5C3.
    exp_rd_q.push_back(7'h12);
    spi_frame(24'h920000, 24, 8, rx);
    post(8, 32'(rx), 32'hA5C3);
    check_drained();

    // Abort after 12 bits, then a clean write.
    base = miso_bad;
    miso_guard = 1'b1;
    exp_err_q.push_back(1'b1);
    spi_frame(24'h225555, 12, 8, rx);
    check_drained();
    exp_q.push_back({7'h01, 16'h0001});
    spi_frame(24'h010001, 24, 8, rx);
    check_drained();

    // 26 sclk pulses: only the first 24 bits count.
    exp_q.push_back({7'h7F, 16'h8001});
    spi_frame(24'h7F8001, 26, 8, rx);
    check_drained();

    // Reset mid-write after 16 bits with ss_n held low.
    ss_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 16; i++) begin
      logic [23:0] f;
      f = 24'h0ACAFE;
      spi_bit(f[23-i], s);
    end
    wait_clk(4);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    check_outputs_zero();
    for (int i = 16; i < 24; i++) begin
      logic [23:0] f;
      f = 24'h0ACAFE;
      spi_bit(f[23-i], s);
    end
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(8);
    check_drained();
    exp_q.push_back({7'h0B, 16'h1357});
    spi_frame(24'h0B1357, 24, 8, rx);
    miso_guard = 1'b0;
    post(7, 32'(miso_bad - base), 32'h0);
    check_drained();

    // Back-to-back write then read of 0x03 with a 4-clock ss_n gap.
    exp_q.push_back({7'h03, 16'h1234});
    spi_frame(24'h031234, 24, 4, rx);
    exp_rd_q.push_back(7'h03);
    spi_frame(24'h830000, 24, 8, rx);
    post(8, 32'(rx), 32'h1234);
    check_drained();

    wait_clk(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
